// File: rtl/reg_fetch_bypass_if.sv
// Bus between the scheduler, the register-fetch stage and Ex.
// The master side (scheduler / bench) drives instruction and write-back
// fields; the slave side (the stage) drives the ex_* fields towards Ex.
interface reg_fetch_bypass_if #(
    parameter int XLEN      = 32,
    parameter int NUM_REGS  = 32,
    parameter int NUM_WB    = 2,
    parameter int PAYLOAD_W = 64
);
    localparam int IDX_W = $clog2(NUM_REGS);

    logic                    flush;
    logic                    stall;
    logic                    valid;
    logic [PAYLOAD_W-1:0]    payload;
    logic                    rs1_valid;
    logic [IDX_W-1:0]        rs1_idx;
    logic                    rs2_valid;
    logic [IDX_W-1:0]        rs2_idx;
    logic [NUM_WB-1:0]       wb_valid;
    logic [NUM_WB*IDX_W-1:0] wb_idx;
    logic [NUM_WB*XLEN-1:0]  wb_data;

    logic                    ex_valid;
    logic [PAYLOAD_W-1:0]    ex_payload;
    logic                    ex_rs1_valid;
    logic [IDX_W-1:0]        ex_rs1_idx;
    logic                    ex_rs2_valid;
    logic [IDX_W-1:0]        ex_rs2_idx;
    logic [XLEN-1:0]         ex_data_rs1;
    logic [XLEN-1:0]         ex_data_rs2;

    modport master (
        output flush, stall, valid, payload, rs1_valid, rs1_idx, rs2_valid, rs2_idx,
               wb_valid, wb_idx, wb_data,
        input  ex_valid, ex_payload, ex_rs1_valid, ex_rs1_idx, ex_rs2_valid, ex_rs2_idx,
               ex_data_rs1, ex_data_rs2
    );

    modport slave (
        input  flush, stall, valid, payload, rs1_valid, rs1_idx, rs2_valid, rs2_idx,
               wb_valid, wb_idx, wb_data,
        output ex_valid, ex_payload, ex_rs1_valid, ex_rs1_idx, ex_rs2_valid, ex_rs2_idx,
               ex_data_rs1, ex_data_rs2
    );
endinterface

// File: rtl/reg_fetch_bypass.sv
// Register-fetch stage: flop register file with several write-back ports,
// same-cycle write-back forwarding into the operands, and refresh of held
// operands while the stage is stalled so Ex always sees current values.
module reg_fetch_bypass #(
    parameter int XLEN      = 32,
    parameter int NUM_REGS  = 32,
    parameter int NUM_WB    = 2,
    parameter int PAYLOAD_W = 64,
    parameter int ZERO_REG  = 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    reg_fetch_bypass_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_REGS);
    localparam logic [IDX_W:0] REG_LIMIT = NUM_REGS[IDX_W:0];

    logic [XLEN-1:0]      rf      [NUM_REGS];
    logic [XLEN-1:0]      rf_next [NUM_REGS];

    logic                 q_valid;
    logic [PAYLOAD_W-1:0] q_payload;
    logic                 q_rs1_valid;
    logic [IDX_W-1:0]     q_rs1_idx;
    logic                 q_rs2_valid;
    logic [IDX_W-1:0]     q_rs2_idx;
    logic [XLEN-1:0]      q_data1;
    logic [XLEN-1:0]      q_data2;

    logic                 src1_hit, src2_hit, held1_hit, held2_hit;
    logic [XLEN-1:0]      src1_wb, src2_wb, held1_wb, held2_wb;
    logic [XLEN-1:0]      src1_sel, src2_sel;

    // An index names a real, writable register: in range and not the hardwired zero.
    function automatic logic live_reg(input logic v, input logic [IDX_W-1:0] idx);
        logic in_range;
        logic is_zero;
        in_range = ({1'b0, idx} < REG_LIMIT);
        is_zero  = (ZERO_REG != 0) && (idx == '0);
        return v && in_range && !is_zero;
    endfunction

    // Find the highest-numbered write-back matching each incoming and each held source.
    always_comb begin
        src1_hit  = 1'b0;
        src2_hit  = 1'b0;
        held1_hit = 1'b0;
        held2_hit = 1'b0;
        src1_wb   = '0;
        src2_wb   = '0;
        held1_wb  = '0;
        held2_wb  = '0;
        for (int p = 0; p < NUM_WB; p++) begin
            if (bus.wb_valid[p]) begin
                if (bus.wb_idx[p*IDX_W +: IDX_W] == bus.rs1_idx) begin
                    src1_hit = 1'b1;
                    src1_wb  = bus.wb_data[p*XLEN +: XLEN];
                end
                if (bus.wb_idx[p*IDX_W +: IDX_W] == bus.rs2_idx) begin
                    src2_hit = 1'b1;
                    src2_wb  = bus.wb_data[p*XLEN +: XLEN];
                end
                if (bus.wb_idx[p*IDX_W +: IDX_W] == q_rs1_idx) begin
                    held1_hit = 1'b1;
                    held1_wb  = bus.wb_data[p*XLEN +: XLEN];
                end
                if (bus.wb_idx[p*IDX_W +: IDX_W] == q_rs2_idx) begin
                    held2_hit = 1'b1;
                    held2_wb  = bus.wb_data[p*XLEN +: XLEN];
                end
            end
        end
    end

    // Operand for each incoming source: zero, forwarded write-back, or array value.
    always_comb begin
        src1_sel = '0;
        src2_sel = '0;
        if (live_reg(bus.rs1_valid, bus.rs1_idx)) begin
            src1_sel = src1_hit ? src1_wb : rf[bus.rs1_idx];
        end
        if (live_reg(bus.rs2_valid, bus.rs2_idx)) begin
            src2_sel = src2_hit ? src2_wb : rf[bus.rs2_idx];
        end
    end

    // Next register-file contents; ascending port order lets the highest port win.
    always_comb begin
        rf_next = rf;
        for (int p = 0; p < NUM_WB; p++) begin
            if (bus.wb_valid[p] && live_reg(1'b1, bus.wb_idx[p*IDX_W +: IDX_W])) begin
                rf_next[bus.wb_idx[p*IDX_W +: IDX_W]] = bus.wb_data[p*XLEN +: XLEN];
            end
        end
    end

    // Register file commits write-backs every edge, independent of stall and flush.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rf <= '{default: '0};
        end else begin
            rf <= rf_next;
        end
    end

    // Stage register: flush beats stall beats advance; stall refreshes held operands.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            q_valid     <= 1'b0;
            q_payload   <= '0;
            q_rs1_valid <= 1'b0;
            q_rs1_idx   <= '0;
            q_rs2_valid <= 1'b0;
            q_rs2_idx   <= '0;
            q_data1     <= '0;
            q_data2     <= '0;
        end else if (bus.flush) begin
            q_valid     <= 1'b0;
            q_payload   <= '0;
            q_rs1_valid <= 1'b0;
            q_rs1_idx   <= '0;
            q_rs2_valid <= 1'b0;
            q_rs2_idx   <= '0;
            q_data1     <= '0;
            q_data2     <= '0;
        end else if (bus.stall) begin
            if (live_reg(q_rs1_valid, q_rs1_idx) && held1_hit) begin
                q_data1 <= held1_wb;
            end
            if (live_reg(q_rs2_valid, q_rs2_idx) && held2_hit) begin
                q_data2 <= held2_wb;
            end
        end else begin
            q_valid     <= bus.valid;
            q_payload   <= bus.payload;
            q_rs1_valid <= bus.rs1_valid;
            q_rs1_idx   <= bus.rs1_idx;
            q_rs2_valid <= bus.rs2_valid;
            q_rs2_idx   <= bus.rs2_idx;
            q_data1     <= src1_sel;
            q_data2     <= src2_sel;
        end
    end

    assign bus.ex_valid     = q_valid;
    assign bus.ex_payload   = q_payload;
    assign bus.ex_rs1_valid = q_rs1_valid;
    assign bus.ex_rs1_idx   = q_rs1_idx;
    assign bus.ex_rs2_valid = q_rs2_valid;
    assign bus.ex_rs2_idx   = q_rs2_idx;
    assign bus.ex_data_rs1  = q_data1;
    assign bus.ex_data_rs2  = q_data2;
endmodule
